// File: rtl/wb_write_arbiter_if.sv
// wb_write_arbiter_if
//   Bundles the producer-side handshakes (ALU result, load result) and the
//   register-file write port driven by wb_write_arbiter.
//   Modports:
//     master : used by the arbiter; it consumes ALU/load results and drives
//              the register-file write port (rd / DataWr / RUWr), ld_ready
//              and the live queue occupancy q_count.
//     slave  : the opposite view, for producers and the register file.
//   Parameters: DEPTH (load queue entries), XLEN (data width).
interface wb_write_arbiter_if #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;

  logic            ld_valid;
  logic            ld_ready;
  logic [4:0]      ld_rd;
  logic [XLEN-1:0] ld_data;

  logic [4:0]      rd;
  logic [XLEN-1:0] DataWr;
  logic            RUWr;
  logic [CW-1:0]   q_count;

  modport master (
    input  alu_valid, alu_rd, alu_data,
    input  ld_valid, ld_rd, ld_data,
    output ld_ready,
    output rd, DataWr, RUWr, q_count
  );

  modport slave (
    output alu_valid, alu_rd, alu_data,
    output ld_valid, ld_rd, ld_data,
    input  ld_ready,
    input  rd, DataWr, RUWr, q_count
  );
endinterface

// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter
//   Write-side master for the register file write port. Merges writebacks
//   from the single-cycle ALU path and the variable-latency load path so the
//   register file sees at most one write per cycle.
//   - ALU writes always win and issue one cycle after alu_valid.
//   - Load results wait in an in-order queue of DEPTH entries (power of two).
//     With nothing queued and no ALU write, a load bypasses the queue and
//     issues the following cycle.
//   - An ALU write to register r marks every queued load to r as killed; a
//     killed entry is popped without a write so it can never overwrite the
//     newer ALU value.
//   - Writes to x0 are never issued (ALU to x0 counts as no request, load to
//     x0 is accepted and discarded).
//   Ports:
//     Clk, Rst : clock, synchronous active-high reset
//     bus      : wb_write_arbiter_if.master (ALU/load inputs, ld_ready,
//                rd/DataWr/RUWr registered write port, q_count occupancy)
//   Optional build macro WB_FWD_EN adds combinational read forwarding:
//     rs1, rs2 (in), rf_rs1, rf_rs2 (in), fwd_rs1, fwd_rs2 (out).
module wb_write_arbiter #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input logic Clk,
  input logic Rst,
  wb_write_arbiter_if.master bus
`ifdef WB_FWD_EN
  ,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  input  logic [XLEN-1:0] rf_rs1,
  input  logic [XLEN-1:0] rf_rs2,
  output logic [XLEN-1:0] fwd_rs1,
  output logic [XLEN-1:0] fwd_rs2
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [4:0]       q_rd   [DEPTH];
  logic [XLEN-1:0]  q_data [DEPTH];
  logic [DEPTH-1:0] q_kill;
  logic [AW-1:0]    head;
  logic [AW-1:0]    tail;
  logic [CW-1:0]    count;

  logic alu_req;
  logic ld_acc;
  logic ld_live;
  logic q_empty;
  logic do_pop;
  logic do_direct;
  logic do_push;
  logic push_kill;

  // Ready depends on the registered count only, so a same-cycle pop from a
  // full queue does not raise it until the next cycle.
  assign bus.ld_ready = (count != FULL);
  assign bus.q_count  = count;

  assign alu_req   = bus.alu_valid && (bus.alu_rd != 5'd0);
  assign ld_acc    = bus.ld_valid && bus.ld_ready;
  assign ld_live   = ld_acc && (bus.ld_rd != 5'd0);
  assign q_empty   = (count == '0);
  assign do_pop    = !alu_req && !q_empty;
  assign do_direct = !alu_req && q_empty && ld_live;
  assign do_push   = ld_live && !do_direct;
  // A load arriving together with an ALU write to the same register is
  // already stale; it still occupies its slot to keep ordering simple.
  assign push_kill = alu_req && (bus.alu_rd == bus.ld_rd);

  // Queue payload: pure data, written on push only.
  always_ff @(posedge Clk) begin
    if (do_push && !Rst) begin
      q_rd[tail]   <= bus.ld_rd;
      q_data[tail] <= bus.ld_data;
    end
  end

  // Issue stage: selection result registered onto the write port.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      q_kill     <= '0;
      bus.rd     <= 5'd0;
      bus.DataWr <= '0;
      bus.RUWr   <= 1'b0;
    end else begin
      if (alu_req) begin
        bus.RUWr   <= 1'b1;
        bus.rd     <= bus.alu_rd;
        bus.DataWr <= bus.alu_data;
        for (int i = 0; i < DEPTH; i++) begin
          if (q_rd[i] == bus.alu_rd) q_kill[i] <= 1'b1;
        end
      end else if (do_pop) begin
        bus.RUWr <= !q_kill[head];
        if (!q_kill[head]) begin
          bus.rd     <= q_rd[head];
          bus.DataWr <= q_data[head];
        end
        head <= head + AW'(1);
      end else if (do_direct) begin
        bus.RUWr   <= 1'b1;
        bus.rd     <= bus.ld_rd;
        bus.DataWr <= bus.ld_data;
      end else begin
        bus.RUWr <= 1'b0;
      end

      // Placed after the squash loop so a fresh entry's kill bit wins over
      // any stale match on the slot it reuses.
      if (do_push) begin
        q_kill[tail] <= push_kill;
        tail         <= tail + AW'(1);
      end

      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

`ifdef WB_FWD_EN
  assign fwd_rs1 = (bus.RUWr && (bus.rd == rs1) && (rs1 != 5'd0)) ? bus.DataWr : rf_rs1;
  assign fwd_rs2 = (bus.RUWr && (bus.rd == rs2) && (rs2 != 5'd0)) ? bus.DataWr : rf_rs2;
`endif

endmodule

// File: tb/tb_wb_write_arbiter.sv
// tb_wb_write_arbiter
//   Directed scenarios followed by randomized traffic, all checked against a
//   queue-based reference model of the write-back rules.
module tb_wb_write_arbiter;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;

  logic Clk = 1'b0;
  logic Rst = 1'b1;

  always #5 Clk = ~Clk;

  wb_write_arbiter_if #(.DEPTH(DEPTH), .XLEN(XLEN)) bus ();

`ifdef WB_FWD_EN
  logic [4:0]      rs1 = 5'd0;
  logic [4:0]      rs2 = 5'd0;
  logic [XLEN-1:0] rf_rs1 = '0;
  logic [XLEN-1:0] rf_rs2 = '0;
  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;
`endif

  wb_write_arbiter #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
`ifdef WB_FWD_EN
    ,
    .rs1     (rs1),
    .rs2     (rs2),
    .rf_rs1  (rf_rs1),
    .rf_rs2  (rf_rs2),
    .fwd_rs1 (fwd_rs1),
    .fwd_rs2 (fwd_rs2)
`endif
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    bit          kill;
  } ent_t;

  ent_t        mq[$];
  logic        m_we   = 1'b0;
  logic [4:0]  m_rd   = 5'd0;
  logic [31:0] m_data = 32'd0;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: ALU first, then oldest queued load, then a bypassing load.
  task automatic model_step();
    bit   alu_req, acc, live, used;
    ent_t e;
    alu_req = bus.alu_valid && (bus.alu_rd != 5'd0);
    acc     = bus.ld_valid && (mq.size() < DEPTH);
    live    = acc && (bus.ld_rd != 5'd0);
    used    = 0;
    m_we    = 1'b0;
    if (alu_req) begin
      m_we   = 1'b1;
      m_rd   = bus.alu_rd;
      m_data = bus.alu_data;
      foreach (mq[i]) if (mq[i].rd == bus.alu_rd) mq[i].kill = 1;
    end else if (mq.size() != 0) begin
      e = mq.pop_front();
      if (!e.kill) begin
        m_we   = 1'b1;
        m_rd   = e.rd;
        m_data = e.data;
      end
    end else if (live) begin
      m_we   = 1'b1;
      m_rd   = bus.ld_rd;
      m_data = bus.ld_data;
      used   = 1;
    end
    if (live && !used)
      mq.push_back('{bus.ld_rd, bus.ld_data, alu_req && (bus.alu_rd == bus.ld_rd)});
  endtask

  task automatic tick(input string tag);
    if (!Rst) chk({tag, ".ready"}, 32'(bus.ld_ready), 32'(mq.size() < DEPTH));
    if (Rst) begin
      mq.delete();
      m_we   = 1'b0;
      m_rd   = 5'd0;
      m_data = 32'd0;
    end else begin
      model_step();
    end
`ifdef WB_FWD_EN
    rs1    = 5'($urandom_range(0, 7));
    rs2    = 5'($urandom_range(0, 7));
    rf_rs1 = $urandom;
    rf_rs2 = $urandom;
`endif
    @(posedge Clk);
    #1;
    chk({tag, ".we"},    32'(bus.RUWr),    32'(m_we));
    chk({tag, ".rd"},    32'(bus.rd),      32'(m_rd));
    chk({tag, ".data"},  bus.DataWr,       m_data);
    chk({tag, ".count"}, 32'(bus.q_count), 32'(mq.size()));
`ifdef WB_FWD_EN
    chk({tag, ".fwd1"}, fwd_rs1, (m_we && m_rd == rs1 && rs1 != 0) ? m_data : rf_rs1);
    chk({tag, ".fwd2"}, fwd_rs2, (m_we && m_rd == rs2 && rs2 != 0) ? m_data : rf_rs2);
`endif
  endtask

  task automatic idle_inputs();
    bus.alu_valid = 1'b0;
    bus.alu_rd    = 5'd0;
    bus.alu_data  = 32'd0;
    bus.ld_valid  = 1'b0;
    bus.ld_rd     = 5'd0;
    bus.ld_data   = 32'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    bit acc_now;
    idle_inputs();

    // Reset
    Rst = 1'b1;
    tick("rst0");
    tick("rst1");
    chk("rst.we", 32'(bus.RUWr), 32'd0);
    chk("rst.cnt", 32'(bus.q_count), 32'd0);
    chk("rst.ready", 32'(bus.ld_ready), 32'd1);
    Rst = 1'b0;

    // Single ALU write
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'd45;
    tick("alu");
    chk("alu.we1", 32'(bus.RUWr), 32'd1);
    chk("alu.rd5", 32'(bus.rd), 32'd5);
    chk("alu.d45", bus.DataWr, 32'd45);
    idle_inputs();
    tick("alu.after");
    chk("alu.we0", 32'(bus.RUWr), 32'd0);

    // x0 filtering
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'd123;
    tick("x0.alu");
    chk("x0.alu.we", 32'(bus.RUWr), 32'd0);
    idle_inputs();
    bus.ld_valid = 1'b1; bus.ld_rd = 5'd0; bus.ld_data = 32'd77;
    tick("x0.ld");
    idle_inputs();
    tick("x0.idle");
    chk("x0.we", 32'(bus.RUWr), 32'd0);
    chk("x0.cnt", 32'(bus.q_count), 32'd0);

    // Collision: ALU and load in the same cycle
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd10; bus.alu_data = 32'd100;
    bus.ld_valid  = 1'b1; bus.ld_rd  = 5'd11; bus.ld_data  = 32'd200;
    tick("col0");
    chk("col.rd10", 32'(bus.rd), 32'd10);
    chk("col.cnt1", 32'(bus.q_count), 32'd1);
    idle_inputs();
    tick("col1");
    chk("col.rd11", 32'(bus.rd), 32'd11);
    chk("col.d200", bus.DataWr, 32'd200);
    chk("col.cnt0", 32'(bus.q_count), 32'd0);

    // Squash: queued load to x7 overtaken by three ALU writes to x7
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 32'd33;
    bus.ld_valid  = 1'b1; bus.ld_rd  = 5'd7; bus.ld_data  = 32'd1;
    tick("sq.fill");
    bus.ld_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.alu_rd = 5'd7; bus.alu_data = 32'd9;
      tick("sq.alu");
      chk("sq.d9", bus.DataWr, 32'd9);
    end
    idle_inputs();
    tick("sq.pop");
    chk("sq.silent", 32'(bus.RUWr), 32'd0);
    chk("sq.hold9", bus.DataWr, 32'd9);
    tick("sq.idle");

    // Backpressure: ALU held busy, five loads offered
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd3;
    for (int k = 0; k < 5; k++) begin
      bus.ld_valid = 1'b1; bus.ld_rd = 5'(12 + k); bus.ld_data = 32'h100 + 32'(k);
      guard = 0;
      do begin
        bus.alu_data = $urandom;
        if (guard >= 2) bus.alu_valid = 1'b0;
        acc_now = (mq.size() < DEPTH);
        tick("bp");
        guard++;
      end while (!acc_now && guard < 12);
      chk("bp.accepted", 32'(acc_now), 32'd1);
      if (k == 3) chk("bp.full", 32'(bus.ld_ready), 32'd0);
    end
    idle_inputs();
    for (int k = 0; k < 6; k++) tick("bp.drain");
    chk("bp.empty", 32'(bus.q_count), 32'd0);

    // Reset mid-drain with three entries left
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd2; bus.alu_data = 32'hABCD;
    for (int k = 0; k < 4; k++) begin
      bus.ld_valid = 1'b1; bus.ld_rd = 5'(20 + k); bus.ld_data = 32'h200 + 32'(k);
      tick("mr.fill");
    end
    idle_inputs();
    tick("mr.pop");
    chk("mr.cnt3", 32'(bus.q_count), 32'd3);
    Rst = 1'b1;
    tick("mr.rst");
    Rst = 1'b0;
    chk("mr.we", 32'(bus.RUWr), 32'd0);
    chk("mr.cnt0", 32'(bus.q_count), 32'd0);
    chk("mr.ready", 32'(bus.ld_ready), 32'd1);
    for (int k = 0; k < 4; k++) tick("mr.idle");

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      Rst           = ($urandom_range(0, 149) == 0);
      bus.alu_valid = 1'($urandom_range(0, 99) < 45);
      bus.alu_rd    = 5'($urandom_range(0, 7));
      bus.alu_data  = $urandom;
      bus.ld_valid  = 1'($urandom_range(0, 99) < 60);
      bus.ld_rd     = 5'($urandom_range(0, 7));
      bus.ld_data   = $urandom;
      tick("rnd");
    end
    Rst = 1'b0;
    idle_inputs();
    for (int k = 0; k < 6; k++) tick("rnd.drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
